axis_ramp_source: RTL
=====================

# axis_ramp_source

DREG-programmed AXIS stream source: software writes a start value, a per-sample increment and a sample count, and the block emits that many samples as an arithmetic ramp on its AXIS master port. It is the generating counterpart of the stream monitor. It drives test patterns into a processing chain whose output a monitor counts and samples. With a zero step it emits a constant; with an all-ones count it runs continuously until stopped.

## Interface

- DATA_WIDTH, 16, width of sample and step registers and of m_tdata
- COUNTER_WIDTH, 32, width of the remaining-count register

- clock  input  1  clock
- reset  input  1  reset, synchronous, active-high
- m_tdata  output  DATA_WIDTH  current sample, equals sample_dout
- m_tvalid  output  1  high while count_dout != 0
- m_tready  input  1  downstream ready
- m_tlast  output  1  high when count_dout == 1
- count_dout  output  COUNTER_WIDTH  remaining samples (all-ones = continuous)
- count_din  input  COUNTER_WIDTH  count write data
- count_dset  input  1  count write strobe, one cycle
- sample_dout  output  DATA_WIDTH  next sample to emit
- sample_din  input  DATA_WIDTH  sample write data
- sample_dset  input  1  sample write strobe
- step_dout  output  DATA_WIDTH  increment added after each transfer
- step_din  input  DATA_WIDTH  step write data
- step_dset  input  1  step write strobe

## Operation

- States are implied by count_dout:
  - IDLE: count_dout == 0.
  - BURST: 0 < count_dout < all-ones.
  - CONT: count_dout == all-ones.
- Busy = BURST or CONT.
- Transfer = m_tvalid && m_tready.
- Register updates, priority highest first:
  - count_dout:
    - reset -> 0.
    - count_dset && count_din == 0 -> 0 (stop/abort, accepted in any state).
    - count_dset && IDLE -> count_din.
    - count_dset && busy && count_din != 0 -> ignored.
    - transfer in BURST -> count_dout - 1.
    - transfer in CONT -> unchanged.
  - sample_dout:
    - reset -> 0.
    - sample_dset && IDLE -> sample_din.
    - transfer -> sample_dout + step_dout, modulo 2^DATA_WIDTH (wraps, no saturation).
    - sample_dset while busy -> ignored.
  - step_dout:
    - reset -> 0.
    - step_dset && IDLE -> step_din.
    - step_dset while busy -> ignored.
- m_tdata, m_tvalid and m_tlast are derived only from registers. There is no combinational path from m_tready or from any *_dset/*_din input to any output.
- While m_tvalid is high, m_tdata and m_tlast hold until a transfer. Busy-time writes are ignored to guarantee this.
- Abort is the single deliberate exception: m_tvalid drops without a transfer. Downstream blocks must tolerate it.
- m_tlast is never asserted in CONT.
- Simultaneous events:
  - Start plus sample_dset/step_dset in the same IDLE cycle: all three load. The first emitted sample is sample_din.
  - Abort coinciding with a transfer: the transfer counts as completed, so sample_dout advances. count_dout becomes 0.
  - count_dset with count_din == 0 in IDLE: no-op.
- After a burst ends, sample_dout holds the next ramp value. A subsequent start continues the ramp unless sample is rewritten.

## Timing

- Reset values: count_dout 0, sample_dout 0, step_dout 0, m_tvalid 0, m_tlast 0, m_tdata 0.
- count_dset at cycle N (IDLE, count_din != 0) -> m_tvalid high at N+1.
- First transfer is possible at N+1.
- Throughput is one sample per cycle while m_tready is held high.
- Burst of K samples with m_tready constantly high: transfers on cycles N+1..N+K.
  - m_tlast is high on cycle N+K.
  - m_tvalid is low from N+K+1.
- A register write at cycle N is visible on *_dout at N+1.
- Abort at cycle N -> m_tvalid low at N+1.
- Reset mid-burst -> all outputs at reset values in the next cycle.
- Counter arithmetic is COUNTER_WIDTH bits. Decrement never underflows because it only happens in BURST.

## Test plan

- Reset, then write sample 100, step 3, count 4 with m_tready=1 -> data 100,103,106,109 on four consecutive cycles; m_tlast only with 109; count_dout reads 0 and sample_dout reads 112 afterwards.
- Same burst with m_tready toggling 1,0,0,1,0,1,1 -> exactly 4 transfers; m_tdata/m_tlast stable while m_tvalid && !m_tready; count_dout decrements only on transfers.
- DATA_WIDTH=16, sample 0xFFFE, step 1, count 3 -> data 0xFFFE,0xFFFF,0x0000 (wrap).
- Count all-ones, step 0, sample 7 -> continuous 7s, m_tlast never high, count_dout stays all-ones; write count 0 -> m_tvalid low next cycle.
- Mid-burst writes: sample_dset, step_dset and count_dset with count_din=5 while busy -> all ignored, ramp and count unaffected.
- Abort coinciding with a transfer -> count 0, sample advanced by step; assert reset mid-burst -> all outputs zero next cycle.

Source files
------------

// File: rtl/axis_ramp_source.sv
// axis_ramp_source
//
// Register-programmed AXI-Stream source. Software loads a start sample, a
// per-transfer step and a sample count; the block then emits an arithmetic
// ramp (sample, sample+step, ...) on its AXIS master port. A count of
// all-ones runs continuously, and writing a count of zero stops the stream.
//
// Handshake: a beat moves on a rising clock edge where m_tvalid && m_tready.
// m_tvalid, m_tdata and m_tlast come straight from registers. While m_tvalid
// is high they stay stable until that beat moves. The one exception is a zero
// count write (abort), which drops m_tvalid without a transfer.
//
// Ports
//   clock, reset             : clock and synchronous active-high reset
//   m_tdata/m_tvalid/m_tlast : AXIS master outputs
//   m_tready                 : AXIS master ready input
//   count_dout/din/dset      : remaining-sample register (all-ones = continuous)
//   sample_dout/din/dset     : next sample to emit
//   step_dout/din/dset       : increment added after each transfer
module axis_ramp_source #(
  parameter int DATA_WIDTH    = 16,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [DATA_WIDTH-1:0]    m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [COUNTER_WIDTH-1:0] count_dout,
  input  logic [COUNTER_WIDTH-1:0] count_din,
  input  logic                     count_dset,
  output logic [DATA_WIDTH-1:0]    sample_dout,
  input  logic [DATA_WIDTH-1:0]    sample_din,
  input  logic                     sample_dset,
  output logic [DATA_WIDTH-1:0]    step_dout,
  input  logic [DATA_WIDTH-1:0]    step_din,
  input  logic                     step_dset
);

  // The operating state is fully encoded by the count register; this decoded
  // view exists so checkers can bind to a named state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_CONT  = 2'd2
  } state_e;

  localparam logic [COUNTER_WIDTH-1:0] CNT_CONT = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] count_q,  count_d;
  logic [DATA_WIDTH-1:0]    sample_q, sample_d;
  logic [DATA_WIDTH-1:0]    step_q,   step_d;

  state_e state;
  logic   idle;
  logic   xfer;

  always_comb begin
    if (count_q == '0)          state = ST_IDLE;
    else if (count_q == CNT_CONT) state = ST_CONT;
    else                        state = ST_BURST;
  end

  assign idle = (state == ST_IDLE);
  assign xfer = !idle && m_tready;

  always_comb begin
    count_d  = count_q;
    sample_d = sample_q;
    step_d   = step_q;

    // Abort wins over everything, including a transfer in the same cycle;
    // that transfer still completes, so the sample below still advances.
    if (count_dset && count_din == '0) begin
      count_d = '0;
    end else if (count_dset && idle) begin
      count_d = count_din;
    end else if (xfer && state == ST_BURST) begin
      count_d = count_q - CNT_ONE;
    end

    // Busy-time writes are dropped so the presented beat never changes
    // underneath a stalled consumer.
    if (sample_dset && idle) begin
      sample_d = sample_din;
    end else if (xfer) begin
      sample_d = sample_q + step_q;
    end

    if (step_dset && idle) begin
      step_d = step_din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      sample_q <= '0;
      step_q   <= '0;
    end else begin
      count_q  <= count_d;
      sample_q <= sample_d;
      step_q   <= step_d;
    end
  end

  assign count_dout  = count_q;
  assign sample_dout = sample_q;
  assign step_dout   = step_q;
  assign m_tdata     = sample_q;
  assign m_tvalid    = !idle;
  // Never asserted in continuous mode since all-ones is not one.
  assign m_tlast     = (count_q == CNT_ONE);

endmodule
